// File: rtl/img_proc_pkg.sv
// Shared types, constants and arithmetic helpers for the img_proc_pipe pixel pipeline.
package img_proc_pkg;

  typedef enum logic [1:0] {
    MODE_GREY      = 2'd0,
    MODE_SOBEL_X   = 2'd1,
    MODE_SOBEL_Y   = 2'd2,
    MODE_SOBEL_MAG = 2'd3
  } mode_e;

  // Cycles from an accepted input pixel to its output pixel.
  localparam int unsigned PIPE_LAT = 4;

  // Gx kernel, indexed [row][col] with row 0 = oldest line and col 0 = oldest column.
  // Gy is its transpose.
  localparam int signed SOBEL_X [3][3] = '{'{-1, 0, 1}, '{-2, 0, 2}, '{-1, 0, 1}};

  function automatic logic [31:0] abs_val(input logic signed [31:0] v);
    return (v < 0) ? $unsigned(-v) : $unsigned(v);
  endfunction

  // Clamp v to the largest value representable in w bits.
  function automatic logic [31:0] sat_val(input logic [31:0] v, input int unsigned w);
    logic [31:0] max_v;
    max_v = (32'd1 << w) - 32'd1;
    return (v > max_v) ? max_v : v;
  endfunction

endpackage

// File: rtl/line_buffer_n.sv
// line_buffer_n: clock-enabled DEPTH-stage shift register; tap_o is the entry pushed DEPTH
// enables ago. Contents are deliberately not reset.
module line_buffer_n #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned DEPTH = 640
) (
  input  logic             clk_i,
  input  logic             clken_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] tap_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  // Shift one position when enabled, newest entry at index 0.
  always_comb begin
    mem_d = mem_q;
    if (clken_i) begin
      mem_d[0] = data_i;
      for (int i = 1; i < int'(DEPTH); i++) begin
        mem_d[i] = mem_q[i-1];
      end
    end
  end

  // Storage register.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign tap_o = mem_q[DEPTH-1];

endmodule

// File: rtl/img_proc_pipe.sv
// img_proc_pipe: streaming RGB -> greyscale / Sobel pipeline, one output per accepted input,
// fixed PIPE_LAT cycles. Define IMG_PROC_THRESH_EN to add iTHRESH and binarise Sobel results.
module img_proc_pipe
  import img_proc_pkg::*;
#(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned IMG_W  = 640,
  parameter int unsigned IMG_H  = 480
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iDVAL,
  input  logic              iSOF,
  input  logic [DATA_W-1:0] iRED,
  input  logic [DATA_W-1:0] iGREEN,
  input  logic [DATA_W-1:0] iBLUE,
  input  logic [1:0]        iMODE,
`ifdef IMG_PROC_THRESH_EN
  input  logic [DATA_W-1:0] iTHRESH,
`endif
  output logic [DATA_W-1:0] oDATA,
  output logic              oDVAL
);

  localparam int unsigned COL_W = (IMG_W > 4) ? $clog2(IMG_W) : 2;
  localparam int unsigned ROW_W = (IMG_H > 4) ? $clog2(IMG_H) : 2;
  localparam int unsigned SUM_W = DATA_W + 4;
  localparam logic [DATA_W-1:0] PIX_MAX = '1;

  logic [COL_W-1:0]        col_q, col_d, cur_col;
  logic [ROW_W-1:0]        row_q, row_d, cur_row;
  logic [PIPE_LAT-1:0]     vld_q, vld_d;
  logic [DATA_W+1:0]       grey_sum;
  logic [DATA_W-1:0]       grey1_q, grey1_d, grey2_q, grey2_d, grey3_q, grey3_d;
  mode_e                   mode1_q, mode1_d, mode2_q, mode2_d, mode3_q, mode3_d;
  logic                    bord1_q, bord1_d, bord2_q, bord2_d, bord3_q, bord3_d;
  logic [DATA_W-1:0]       tap0, tap1;
  logic                    lb_en;
  logic [DATA_W-1:0]       win_q [3][3];
  logic [DATA_W-1:0]       win_d [3][3];
  int                      gx_sum, gy_sum;
  logic signed [SUM_W-1:0] gx3_q, gx3_d, gy3_q, gy3_d;
  logic [31:0]             gx_abs, gy_abs, mag, mag_sat;
  logic [DATA_W-1:0]       conv, data_q, data_d;
  logic                    unused_bits;

  // Stage 1: position counters (iSOF forces (0,0)), greyscale conversion, border flag.
  always_comb begin
    cur_col = (iDVAL && iSOF) ? '0 : col_q;
    cur_row = (iDVAL && iSOF) ? '0 : row_q;
    col_d   = col_q;
    row_d   = row_q;
    if (iDVAL) begin
      if (cur_col == COL_W'(IMG_W - 1)) begin
        col_d = '0;
        row_d = (cur_row == ROW_W'(IMG_H - 1)) ? '0 : cur_row + 1'b1;
      end else begin
        col_d = cur_col + 1'b1;
        row_d = cur_row;
      end
    end
    grey_sum = {2'b00, iRED} + {1'b0, iGREEN, 1'b0} + {2'b00, iBLUE};
    grey1_d  = grey_sum[DATA_W+1:2];
    mode1_d  = mode_e'(iMODE);
    bord1_d  = (cur_row < ROW_W'(2)) || (cur_col < COL_W'(2));
    vld_d    = {vld_q[PIPE_LAT-2:0], iDVAL};
  end

  // Pushes are held off during reset so aborted pixels never enter the line history.
  assign lb_en = vld_q[0] & iRST;

  line_buffer_n #(
    .WIDTH (DATA_W),
    .DEPTH (IMG_W)
  ) u_lb0 (
    .clk_i   (iCLK),
    .clken_i (lb_en),
    .data_i  (grey1_q),
    .tap_o   (tap0)
  );

  line_buffer_n #(
    .WIDTH (DATA_W),
    .DEPTH (IMG_W)
  ) u_lb1 (
    .clk_i   (iCLK),
    .clken_i (lb_en),
    .data_i  (tap0),
    .tap_o   (tap1)
  );

  // Stage 2: 3x3 window shifts left on valid; new column = {two lines up, one line up, now}.
  always_comb begin
    win_d = win_q;
    if (vld_q[0]) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = tap1;
      win_d[1][2] = tap0;
      win_d[2][2] = grey1_q;
    end
    grey2_d = grey1_q;
    mode2_d = mode1_q;
    bord2_d = bord1_q;
  end

  // Stage 3: signed Gx/Gy convolution over the window.
  always_comb begin
    gx_sum = 0;
    gy_sum = 0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        gx_sum = gx_sum + SOBEL_X[r][c] * int'(win_q[r][c]);
        gy_sum = gy_sum + SOBEL_X[c][r] * int'(win_q[r][c]);
      end
    end
    gx3_d   = gx_sum[SUM_W-1:0];
    gy3_d   = gy_sum[SUM_W-1:0];
    grey3_d = grey2_q;
    mode3_d = mode2_q;
    bord3_d = bord2_q;
  end

  // Stage 4: magnitude select, saturation, optional threshold, border blanking.
  always_comb begin
    gx_abs = abs_val(32'(gx3_q));
    gy_abs = abs_val(32'(gy3_q));
    case (mode3_q)
      MODE_SOBEL_X: mag = gx_abs;
      MODE_SOBEL_Y: mag = gy_abs;
      default:      mag = gx_abs + gy_abs;
    endcase
    mag_sat = sat_val(mag, DATA_W);
    conv    = mag_sat[DATA_W-1:0];
`ifdef IMG_PROC_THRESH_EN
    conv    = (conv >= iTHRESH) ? PIX_MAX : '0;
`endif
    data_d  = data_q;
    if (vld_q[PIPE_LAT-2]) begin
      if (mode3_q == MODE_GREY) begin
        data_d = grey3_q;
      end else begin
        data_d = bord3_q ? '0 : conv;
      end
    end
  end

  assign unused_bits = ^{grey_sum[1:0], gx_sum[31:SUM_W], gy_sum[31:SUM_W], mag_sat[31:DATA_W]};

  // Pipeline registers with synchronous active-low reset; line buffers are not reset.
  always_ff @(posedge iCLK) begin
    if (!iRST) begin
      col_q   <= '0;
      row_q   <= '0;
      vld_q   <= '0;
      grey1_q <= '0;
      grey2_q <= '0;
      grey3_q <= '0;
      mode1_q <= MODE_GREY;
      mode2_q <= MODE_GREY;
      mode3_q <= MODE_GREY;
      bord1_q <= 1'b0;
      bord2_q <= 1'b0;
      bord3_q <= 1'b0;
      win_q   <= '{default: '0};
      gx3_q   <= '0;
      gy3_q   <= '0;
      data_q  <= '0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      vld_q   <= vld_d;
      grey1_q <= grey1_d;
      grey2_q <= grey2_d;
      grey3_q <= grey3_d;
      mode1_q <= mode1_d;
      mode2_q <= mode2_d;
      mode3_q <= mode3_d;
      bord1_q <= bord1_d;
      bord2_q <= bord2_d;
      bord3_q <= bord3_d;
      win_q   <= win_d;
      gx3_q   <= gx3_d;
      gy3_q   <= gy3_d;
      data_q  <= data_d;
    end
  end

  assign oDATA = data_q;
  assign oDVAL = vld_q[PIPE_LAT-1];

endmodule

// File: tb/tb_img_proc_pipe.sv
// tb_img_proc_pipe: randomized and directed stimulus against a frame-array reference model.
module tb_img_proc_pipe;

  localparam int unsigned DATA_W = 12;
  localparam int unsigned IMG_W  = 8;
  localparam int unsigned IMG_H  = 6;
  localparam int          NPIX   = IMG_W * IMG_H;
  localparam int          MAXV   = (1 << DATA_W) - 1;

  logic              iCLK = 1'b0;
  logic              iRST = 1'b0;
  logic              iDVAL = 1'b0;
  logic              iSOF = 1'b0;
  logic [DATA_W-1:0] iRED = '0;
  logic [DATA_W-1:0] iGREEN = '0;
  logic [DATA_W-1:0] iBLUE = '0;
  logic [1:0]        iMODE = '0;
`ifdef IMG_PROC_THRESH_EN
  logic [DATA_W-1:0] iTHRESH = '0;
`endif
  logic [DATA_W-1:0] oDATA;
  logic              oDVAL;

  img_proc_pipe #(
    .DATA_W (DATA_W),
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H)
  ) dut (
    .iCLK    (iCLK),
    .iRST    (iRST),
    .iDVAL   (iDVAL),
    .iSOF    (iSOF),
    .iRED    (iRED),
    .iGREEN  (iGREEN),
    .iBLUE   (iBLUE),
    .iMODE   (iMODE),
`ifdef IMG_PROC_THRESH_EN
    .iTHRESH (iTHRESH),
`endif
    .oDATA   (oDATA),
    .oDVAL   (oDVAL)
  );

  always #5 iCLK = ~iCLK;

  typedef struct {
    int data;
    int due;
  } exp_t;

  exp_t exp_q[$];
  int   out_log[$];
  int   sx_log[$];
  int   cont_log[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   edge_cnt = 0;
  int   img [IMG_H][IMG_W];
  int   m_row = 0;
  int   m_col = 0;
  int   fr_r [NPIX];
  int   fr_g [NPIX];
  int   fr_b [NPIX];

  function automatic int grey_of(int r, int g, int b);
    return (r + 2 * g + b) / 4;
  endfunction

  function automatic int iabs(int v);
    return (v < 0) ? -v : v;
  endfunction

  // Expected output for the pixel just written at (r,c): grey, or Sobel centred at (r-1,c-1).
  function automatic int model_pix(int r, int c, int m, int g, int th);
    int gx, gy, v;
    if (m == 0) return g;
    if (r < 2 || c < 2) return 0;
    gx = (img[r-2][c] - img[r-2][c-2]) + 2 * (img[r-1][c] - img[r-1][c-2])
       + (img[r][c] - img[r][c-2]);
    gy = (img[r][c-2] - img[r-2][c-2]) + 2 * (img[r][c-1] - img[r-2][c-1])
       + (img[r][c] - img[r-2][c]);
    if (m == 1) v = iabs(gx);
    else if (m == 2) v = iabs(gy);
    else v = iabs(gx) + iabs(gy);
    if (v > MAXV) v = MAXV;
`ifdef IMG_PROC_THRESH_EN
    v = (v >= th) ? MAXV : 0;
`else
    if (th < 0) v = 0;
`endif
    return v;
  endfunction

  // Reference model: observes accepted pixels at each rising edge.
  initial begin : model
    exp_t e;
    int   g, th;
    forever begin
      @(posedge iCLK);
      th = 0;
`ifdef IMG_PROC_THRESH_EN
      th = int'(iTHRESH);
`endif
      if (!iRST) begin
        exp_q.delete();
        m_row = 0;
        m_col = 0;
      end else if (iDVAL) begin
        if (iSOF) begin
          m_row = 0;
          m_col = 0;
        end
        g = grey_of(int'(iRED), int'(iGREEN), int'(iBLUE));
        img[m_row][m_col] = g;
        e.data = model_pix(m_row, m_col, int'(iMODE), g, th);
        e.due  = edge_cnt + 4;
        exp_q.push_back(e);
        m_col++;
        if (m_col == IMG_W) begin
          m_col = 0;
          m_row++;
          if (m_row == IMG_H) m_row = 0;
        end
      end
      edge_cnt++;
    end
  end

  // Output comparator, sampled on the falling edge.
  initial begin : compare
    exp_t e;
    forever begin
      @(negedge iCLK);
      if (oDVAL) begin
        out_log.push_back(int'(oDATA));
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL stream: unexpected oDVAL data=%0d at edge %0d", oDATA, edge_cnt);
        end else begin
          e = exp_q.pop_front();
          if (e.due != edge_cnt || e.data != int'(oDATA)) begin
            n_bad++;
            $display("FAIL stream: got data=%0d at edge %0d, required data=%0d at edge %0d",
                     oDATA, edge_cnt, e.data, e.due);
          end
        end
      end else if (exp_q.size() > 0 && exp_q[0].due <= edge_cnt) begin
        n_cmp++;
        n_bad++;
        $display("FAIL stream: missing oDVAL, required data=%0d at edge %0d",
                 exp_q[0].data, exp_q[0].due);
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic check(string name, int got, int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, got, want);
    end
  endtask

  task automatic idle(int n);
    repeat (n) @(negedge iCLK);
  endtask

  // Present one pixel for exactly one cycle; call and return at a falling edge.
  task automatic send_pix(int r, int g, int b, int mode, bit sof);
    iRED   = DATA_W'(r);
    iGREEN = DATA_W'(g);
    iBLUE  = DATA_W'(b);
    iMODE  = 2'(mode);
    iSOF   = sof;
    iDVAL  = 1'b1;
    @(negedge iCLK);
    iDVAL  = 1'b0;
    iSOF   = 1'b0;
  endtask

  task automatic send_frame(int mode, bit gaps, bit rand_mode);
    out_log.delete();
    for (int i = 0; i < NPIX; i++) begin
      if (gaps && $urandom_range(1, 0) == 1) idle(int'($urandom_range(2, 1)));
      send_pix(fr_r[i], fr_g[i], fr_b[i], rand_mode ? int'($urandom_range(3, 0)) : mode, i == 0);
    end
    idle(8);
  endtask

  task automatic fill_edge();
    for (int i = 0; i < NPIX; i++) begin
      fr_r[i] = ((i % IMG_W) < 4) ? 0 : MAXV;
      fr_g[i] = fr_r[i];
      fr_b[i] = fr_r[i];
    end
  endtask

  task automatic fill_rand();
    for (int i = 0; i < NPIX; i++) begin
      fr_r[i] = int'($urandom_range(MAXV, 0));
      fr_g[i] = int'($urandom_range(MAXV, 0));
      fr_b[i] = int'($urandom_range(MAXV, 0));
    end
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    idle(3);
    check("reset_odval", int'(oDVAL), 0);
    check("reset_odata", int'(oDATA), 0);
    iRST = 1'b1;
    idle(1);

    // Grey: (100 + 400 + 40) / 4 = 135, output on the 4th edge only.
    check("model_grey", grey_of(100, 200, 40), 135);
    send_pix(100, 200, 40, 0, 1'b1);
    check("grey_lat_e0", int'(oDVAL), 0);
    idle(1);
    check("grey_lat_e1", int'(oDVAL), 0);
    idle(1);
    check("grey_lat_e2", int'(oDVAL), 0);
    idle(1);
    check("grey_dval", int'(oDVAL), 1);
    check("grey_data", int'(oDATA), 135);
    idle(4);

    // Vertical edge between cols 3 and 4.
    fill_edge();
    send_frame(1, 1'b0, 1'b0);
    check("sx_count", out_log.size(), NPIX);
    if (out_log.size() == NPIX) begin
      check("sx_edge_r2c4", out_log[2*IMG_W+4], MAXV);
      check("sx_edge_r4c5", out_log[4*IMG_W+5], MAXV);
      check("sx_flat_r3c6", out_log[3*IMG_W+6], 0);
      check("sx_flat_r3c3", out_log[3*IMG_W+3], 0);
      check("sx_border_r1c4", out_log[1*IMG_W+4], 0);
      check("sx_border_r4c1", out_log[4*IMG_W+1], 0);
    end
    sx_log = out_log;

    send_frame(2, 1'b0, 1'b0);
    check("sy_count", out_log.size(), NPIX);
    foreach (out_log[i]) check("sy_zero", out_log[i], 0);

    send_frame(3, 1'b0, 1'b0);
    check("mag_count", out_log.size(), NPIX);
    if (out_log.size() == NPIX && sx_log.size() == NPIX) begin
      for (int i = 0; i < NPIX; i++) check("mag_eq_sx", out_log[i], sx_log[i]);
    end

    // Same random frame, continuous versus gapped.
    fill_rand();
    send_frame(3, 1'b0, 1'b0);
    cont_log = out_log;
    send_frame(3, 1'b1, 1'b0);
    check("gap_count", out_log.size(), NPIX);
    if (out_log.size() == NPIX && cont_log.size() == NPIX) begin
      for (int i = 0; i < NPIX; i++) check("gap_eq_cont", out_log[i], cont_log[i]);
    end

    // Per-pixel random mode changes with gaps.
    fill_rand();
    send_frame(0, 1'b1, 1'b1);

    // iSOF at row 1 col 5 restarts at (0,0): next two rows of conv output are border zeros.
    fill_rand();
    out_log.delete();
    for (int i = 0; i < 37; i++) send_pix(fr_r[i], fr_g[i], fr_b[i], 1, (i == 0) || (i == 13));
    idle(8);
    check("sof_count", out_log.size(), 37);
    if (out_log.size() == 37) begin
      for (int i = 13; i < 13 + 2 * IMG_W; i++) check("sof_border", out_log[i], 0);
    end

    // Reset with three pixels in flight.
    for (int i = 0; i < 3; i++) send_pix(fr_r[i], fr_g[i], fr_b[i], 0, 1'b0);
    iRST = 1'b0;
    idle(1);
    iRST = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("rst_abort", int'(oDVAL), 0);
      idle(1);
    end
    send_pix(100, 200, 40, 0, 1'b0);
    idle(3);
    check("rst_grey_dval", int'(oDVAL), 1);
    check("rst_grey_data", int'(oDATA), 135);
    idle(4);

`ifdef IMG_PROC_THRESH_EN
    iTHRESH = DATA_W'(2000);
    fill_edge();
    send_frame(1, 1'b0, 1'b0);
    check("th_count", out_log.size(), NPIX);
    if (out_log.size() == NPIX) begin
      check("th_edge_r2c4", out_log[2*IMG_W+4], MAXV);
      check("th_edge_r3c5", out_log[3*IMG_W+5], MAXV);
      check("th_flat_r3c7", out_log[3*IMG_W+7], 0);
      check("th_border_r0c5", out_log[5], 0);
    end
`endif

    idle(2);
    check("drain_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
